// File: rtl/reg_writeback.sv
// reg_writeback
// Writeback stage of the RV32 core and the only writer of the register-file
// write port. It merges single-cycle ALU results with in-order load responses
// from data memory. Load data is byte-lane aligned and sign/zero-extended
// here. A pending-register scoreboard lets decode stall on load-use hazards.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/rd/data/ready  ALU result handshake
//   ld_issue/rd/funct3/off   load issue into the outstanding-load queue
//   ld_ready                 queue not full
//   mem_rvalid, mem_rdata    memory read response (no back-pressure)
//   rd, rd_data, rd_we       registered register-file write port
//   pending                  bit r set while a queued load targets r (bit 0 = 0)
//   protocol_err             sticky: stray response or bad load funct3
module reg_writeback #(
   parameter int LQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_issue,
   input  logic [4:0]  ld_rd,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   output logic        ld_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [4:0]  rd,
   output logic [31:0] rd_data,
   output logic        rd_we,
   output logic [31:0] pending,
   output logic        protocol_err
);

   localparam int PTR_W = $clog2(LQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [1:0] off;
   } lq_entry_t;

   // Load queue storage plus per-slot valid bits (valid bits drive the scoreboard)
   lq_entry_t            lq_mem_q [LQ_DEPTH];
   logic [LQ_DEPTH-1:0]  lq_valid_q, lq_valid_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;

   // Skid register for an ALU result that lost arbitration
   logic                 skid_valid_q, skid_valid_d;
   logic [4:0]           skid_rd_q, skid_rd_d;
   logic [31:0]          skid_data_q, skid_data_d;

   // Registered write port and sticky error
   logic [4:0]           rd_q, rd_d;
   logic [31:0]          rd_data_q, rd_data_d;
   logic                 rd_we_q, rd_we_d;
   logic                 err_q, err_d;

   logic                 lq_push, lq_pop, alu_acc;
   lq_entry_t            head;
   logic [15:0]          lane;
   logic [31:0]          ld_data;
   logic                 bad_funct3;
   logic                 sel_valid;
   logic [4:0]           sel_rd;
   logic [31:0]          sel_data;
   logic [31:0]          pending_v;

   assign ld_ready  = (count_q != CNT_W'(LQ_DEPTH));
   assign alu_ready = !skid_valid_q;
   assign lq_push   = ld_issue && ld_ready;
   assign lq_pop    = mem_rvalid && (count_q != '0);
   assign alu_acc   = alu_valid && alu_ready;
   assign head      = lq_mem_q[rd_ptr_q];

   // Load formatting: only the low halfword of the shifted word is ever used
   // for sub-word loads; LW takes the raw word and ignores the offset.
   always_comb begin
      lane       = 16'(mem_rdata >> {head.off, 3'b000});
      bad_funct3 = 1'b0;
      case (head.funct3)
         3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
         3'b100:  ld_data = {24'b0, lane[7:0]};
         3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
         3'b101:  ld_data = {16'b0, lane[15:0]};
         3'b010:  ld_data = mem_rdata;
         default: begin
            ld_data    = mem_rdata;
            bad_funct3 = 1'b1;
         end
      endcase
   end

   // Scoreboard: OR of one-hot rd over valid slots; x0 is never pending
   always_comb begin
      pending_v = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (lq_valid_q[i]) pending_v[lq_mem_q[i].rd] = 1'b1;
      end
      pending = {pending_v[31:1], 1'b0};
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      lq_valid_d   = lq_valid_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      skid_valid_d = skid_valid_q;
      skid_rd_d    = skid_rd_q;
      skid_data_d  = skid_data_q;
      err_d        = err_q;
      sel_valid    = 1'b0;
      sel_rd       = '0;
      sel_data     = '0;

      // Pointers wrap naturally because LQ_DEPTH is a power of two. Push and
      // pop never hit the same slot: that needs an empty (no pop) or full
      // (no push) queue.
      if (lq_push) begin
         lq_valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (lq_pop) begin
         lq_valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d             = rd_ptr_q + 1'b1;
      end
      if (lq_push && !lq_pop)      count_d = count_q + 1'b1;
      else if (!lq_push && lq_pop) count_d = count_q - 1'b1;

      // Priority: load response, then skid, then fresh ALU input. An ALU
      // input accepted while a response wins is parked in the (empty) skid.
      if (lq_pop) begin
         sel_valid = 1'b1;
         sel_rd    = head.rd;
         sel_data  = ld_data;
         if (alu_acc) begin
            skid_valid_d = 1'b1;
            skid_rd_d    = alu_rd;
            skid_data_d  = alu_data;
         end
      end else if (skid_valid_q) begin
         sel_valid    = 1'b1;
         sel_rd       = skid_rd_q;
         sel_data     = skid_data_q;
         skid_valid_d = 1'b0;
      end else if (alu_acc) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end

      if ((mem_rvalid && (count_q == '0)) || (lq_pop && bad_funct3)) err_d = 1'b1;

      // Writes to x0 still consume their source but never enable the port
      rd_we_d   = sel_valid && (sel_rd != 5'd0);
      rd_d      = sel_valid ? sel_rd : rd_q;
      rd_data_d = sel_valid ? sel_data : rd_data_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         lq_valid_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         skid_valid_q <= 1'b0;
         skid_rd_q    <= '0;
         skid_data_q  <= '0;
         rd_q         <= '0;
         rd_data_q    <= '0;
         rd_we_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         lq_valid_q   <= lq_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         skid_valid_q <= skid_valid_d;
         skid_rd_q    <= skid_rd_d;
         skid_data_q  <= skid_data_d;
         rd_q         <= rd_d;
         rd_data_q    <= rd_data_d;
         rd_we_q      <= rd_we_d;
         err_q        <= err_d;
      end
   end

   // NOTE: queue storage is not reset; the reset valid bits and count make stale contents unobservable.
   always_ff @(posedge clk) begin
      if (lq_push) lq_mem_q[wr_ptr_q] <= '{rd: ld_rd, funct3: ld_funct3, off: ld_off};
   end

   assign rd           = rd_q;
   assign rd_data      = rd_data_q;
   assign rd_we        = rd_we_q;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a queue-based behavioural model is
// compared against the DUT on every negative edge, and directed scenarios
// carry hand-computed literal expectations.
module tb_reg_writeback;

   localparam int LQ_DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_off;
   logic        ld_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rd;
   logic [31:0] rd_data;
   logic        rd_we;
   logic [31:0] pending;
   logic        protocol_err;

   reg_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off), .ld_ready(ld_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rd(rd), .rd_data(rd_data), .rd_we(rd_we),
      .pending(pending), .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [4:0] rd;
      logic [2:0] f3;
      logic [1:0] off;
   } ld_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   ld_t         m_lq[$];
   wr_t         m_skid[$];
   bit          m_ok = 0;
   bit          m_err;
   bit          e_we;
   bit          e_data_chk;
   logic [4:0]  e_rd;
   logic [31:0] e_data;

   function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      logic [31:0] s;
      logic [31:0] b;
      logic [31:0] h;
      s = w >> (8 * off);
      b = s & 32'hFF;
      h = s & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_pending();
      logic [31:0] p;
      p = '0;
      foreach (m_lq[i]) if (m_lq[i].rd != 5'd0) p[m_lq[i].rd] = 1'b1;
      return p;
   endfunction

   always @(posedge clk) begin : model
      bit  alu_rdy, ld_rdy, have_w;
      wr_t w;
      ld_t e;
      if (rst) begin
         m_lq.delete();
         m_skid.delete();
         m_err = 0;
         e_we = 0; e_rd = '0; e_data = '0; e_data_chk = 1;
         m_ok = 1;
      end else if (m_ok) begin
         alu_rdy = (m_skid.size() == 0);
         ld_rdy  = (m_lq.size() < LQ_DEPTH);
         have_w  = 0;
         w       = '{rd: 5'd0, data: 32'd0};
         if (mem_rvalid && m_lq.size() == 0) m_err = 1;
         if (mem_rvalid && m_lq.size() > 0) begin
            e = m_lq.pop_front();
            have_w = 1;
            w = '{rd: e.rd, data: fmt(e.f3, e.off, mem_rdata)};
            if (e.f3 == 3'b011 || e.f3 == 3'b110 || e.f3 == 3'b111) m_err = 1;
            if (alu_valid && alu_rdy) m_skid.push_back('{rd: alu_rd, data: alu_data});
         end else if (m_skid.size() > 0) begin
            have_w = 1;
            w = m_skid.pop_front();
         end else if (alu_valid && alu_rdy) begin
            have_w = 1;
            w = '{rd: alu_rd, data: alu_data};
         end
         if (ld_issue && ld_rdy) m_lq.push_back('{rd: ld_rd, f3: ld_funct3, off: ld_off});
         e_we       = have_w && (w.rd != 5'd0);
         e_data_chk = e_we;
         e_rd       = w.rd;
         e_data     = w.data;
      end
   end

   // Single compare process, outputs sampled away from the active edge
   always @(negedge clk) begin
      if (m_ok) begin
         check("m_rd_we", 32'(rd_we), 32'(e_we));
         check("m_alu_ready", 32'(alu_ready), 32'(m_skid.size() == 0));
         check("m_ld_ready", 32'(ld_ready), 32'(m_lq.size() < LQ_DEPTH));
         check("m_pending", pending, model_pending());
         check("m_protocol_err", 32'(protocol_err), 32'(m_err));
         if (e_data_chk) begin
            check("m_rd", 32'(rd), 32'(e_rd));
            check("m_rd_data", rd_data, e_data);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      ld_issue = 0; ld_rd = '0; ld_funct3 = '0; ld_off = '0;
      mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic alu(input logic [4:0] r, input logic [31:0] d);
      alu_valid = 1; alu_rd = r; alu_data = d;
   endtask

   task automatic ld(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off);
      ld_issue = 1; ld_rd = r; ld_funct3 = f3; ld_off = off;
   endtask

   task automatic resp(input logic [31:0] d);
      mem_rvalid = 1; mem_rdata = d;
   endtask

   // Issue, wait one idle cycle, respond, then check the formatted write
   task automatic do_load(input string name, input logic [4:0] r, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] word, input logic [31:0] exp);
      idle(); ld(r, f3, off); tick();
      check({name, "_pend_issue"}, 32'(pending[r]), 32'd1);
      idle(); tick();
      check({name, "_pend_wait"}, 32'(pending[r]), 32'd1);
      resp(word); tick();
      check({name, "_we"}, 32'(rd_we), 32'd1);
      check({name, "_rd"}, 32'(rd), 32'(r));
      check({name, "_data"}, rd_data, exp);
      check({name, "_pend_clr"}, 32'(pending[r]), 32'd0);
      idle();
   endtask

   initial begin
      rst = 1;
      idle();
      tick();
      tick();
      check("rst_rd_we", 32'(rd_we), 32'd0);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_pending", pending, 32'd0);
      check("rst_err", 32'(protocol_err), 32'd0);
      rst = 0;

      // Basic ALU write
      alu(5'd5, 32'h1234_5678); tick();
      check("alu_we", 32'(rd_we), 32'd1);
      check("alu_rd", 32'(rd), 32'd5);
      check("alu_data", rd_data, 32'h1234_5678);
      idle(); tick();
      check("alu_we_off", 32'(rd_we), 32'd0);

      // Load formatting and scoreboard
      do_load("lb",  5'd3, 3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
      do_load("lbu", 5'd3, 3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080);
      do_load("lhu", 5'd3, 3'b101, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF);
      do_load("lh",  5'd4, 3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
      do_load("lw",  5'd6, 3'b010, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_load("lb3", 5'd2, 3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F);

      // Collision: load response beats the ALU, ALU goes to skid
      ld(5'd9, 3'b010, 2'd0); tick();
      idle(); alu(5'd7, 32'hA); resp(32'hB); tick();
      check("col_rd_load", 32'(rd), 32'd9);
      check("col_data_load", rd_data, 32'hB);
      check("col_alu_ready0", 32'(alu_ready), 32'd0);
      idle(); alu(5'd8, 32'hC); tick();
      check("col_rd_skid", 32'(rd), 32'd7);
      check("col_data_skid", rd_data, 32'hA);
      check("col_alu_ready1", 32'(alu_ready), 32'd1);
      tick();
      check("col_rd_held", 32'(rd), 32'd8);
      check("col_data_held", rd_data, 32'hC);
      idle(); tick();

      // Simultaneous issue and response for the same rd
      ld(5'd5, 3'b010, 2'd0); tick();
      ld(5'd5, 3'b010, 2'd0); resp(32'h55); tick();
      check("same_rd_data", rd_data, 32'h55);
      check("same_rd_pend", 32'(pending[5]), 32'd1);
      idle(); resp(32'h66); tick();
      check("same_rd_data2", rd_data, 32'h66);
      check("same_rd_pend_clr", pending, 32'd0);
      idle();

      // Full queue
      for (int i = 0; i < 4; i++) begin
         ld(5'(10 + i), 3'b010, 2'd0); tick();
      end
      check("full_ld_ready", 32'(ld_ready), 32'd0);
      check("full_pending", pending, 32'h0000_3C00);
      ld(5'd14, 3'b010, 2'd0); tick();
      check("full_refused", pending, 32'h0000_3C00);
      ld(5'd15, 3'b010, 2'd0); resp(32'h11); tick();
      check("full_pop_rd", 32'(rd), 32'd10);
      check("full_pop_data", rd_data, 32'h11);
      check("full_pop_pending", pending, 32'h0000_3800);
      check("full_pop_ready", 32'(ld_ready), 32'd1);
      idle();
      for (int j = 0; j < 3; j++) begin
         resp(32'h100 + 32'(j)); tick();
         check("drain_rd", 32'(rd), 32'(11 + j));
         check("drain_data", rd_data, 32'h100 + 32'(j));
      end
      check("drain_empty", pending, 32'd0);
      idle(); tick();

      // Back-to-back ALU stream
      for (int i = 1; i <= 8; i++) begin
         alu(5'(16 + i), 32'h0101_0101 * 32'(i)); tick();
         check("stream_rd", 32'(rd), 32'(16 + i));
      end
      idle(); tick();

      // x0 writes and loads
      alu(5'd0, 32'hDEAD); tick();
      check("x0_alu_we", 32'(rd_we), 32'd0);
      idle(); ld(5'd0, 3'b010, 2'd0); tick();
      check("x0_ld_pend", pending, 32'd0);
      idle(); resp(32'h77); tick();
      check("x0_ld_we", 32'(rd_we), 32'd0);
      check("x0_ld_err", 32'(protocol_err), 32'd0);
      idle();

      // Illegal funct3 formatted as LW, flags error
      do_load("f011", 5'd20, 3'b011, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE);
      check("f011_err", 32'(protocol_err), 32'd1);
      rst = 1; tick(); rst = 0;
      check("err_cleared", 32'(protocol_err), 32'd0);

      // Response with an empty queue
      resp(32'h1234); tick();
      check("stray_err", 32'(protocol_err), 32'd1);
      check("stray_we", 32'(rd_we), 32'd0);
      idle(); tick(); tick(); tick();
      check("stray_sticky", 32'(protocol_err), 32'd1);

      // Reset mid-flight: two loads pending plus a skid entry
      rst = 1; tick(); rst = 0;
      ld(5'd4, 3'b010, 2'd0); tick();
      ld(5'd6, 3'b010, 2'd0); tick();
      ld(5'd2, 3'b010, 2'd0); tick();
      idle(); alu(5'd7, 32'h70); resp(32'h40); tick();
      check("mid_skid", 32'(alu_ready), 32'd0);
      check("mid_pending", pending, 32'h0000_0044);
      idle(); rst = 1; tick(); rst = 0;
      check("mid_rst_pending", pending, 32'd0);
      check("mid_rst_we", 32'(rd_we), 32'd0);
      check("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
      check("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
      resp(32'h99); tick();
      check("mid_late_err", 32'(protocol_err), 32'd1);
      check("mid_late_we", 32'(rd_we), 32'd0);
      idle(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage for the RV32 core: the single writer that drives the register file's write port (`rd`, `rd_data`, `rd_we`). It merges single-cycle ALU results with out-of-order-in-time (but in-order) load responses from data memory. Load data is sign/zero-extended and byte-lane aligned here. It also publishes a pending-register scoreboard so decode can stall on load-use hazards.

## Interface
Parameters
- `LQ_DEPTH`, 4: outstanding-load queue entries (power of two, ≥2).

Ports
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result present.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU result accepted when `alu_valid && alu_ready`.
- `ld_issue` in 1: load issued to memory this cycle.
- `ld_rd` in 5: load destination register.
- `ld_funct3` in 3: load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `ld_off` in 2: `addr[1:0]` of the load.
- `ld_ready` out 1: queue not full; the issue is accepted when `ld_issue && ld_ready`.
- `mem_rvalid` in 1: memory read response (cannot be back-pressured).
- `mem_rdata` in 32: raw aligned memory word.
- `rd` out 5: register-file write address.
- `rd_data` out 32: register-file write data.
- `rd_we` out 1: register-file write enable.
- `pending` out 32: bit r set while any queued load targets r; bit 0 is always 0.
- `protocol_err` out 1: sticky error flag.

## Operation
- **Load queue.** A FIFO of `{rd, funct3, off}` with `LQ_DEPTH` entries.
  - An accepted issue pushes an entry.
  - `mem_rvalid` pops the head.
  - A push and a pop in the same cycle are both honoured, including when the queue is full: the pop frees the slot, but `ld_ready` is still computed from the current count, so an issue while full is refused.
  - Pointers wrap modulo `LQ_DEPTH`.
- **Load formatting.**
  - Compute `lane = mem_rdata >> (8*off)`.
  - LB/LBU take `lane[7:0]`, sign- or zero-extended to 32 bits.
  - LH/LHU take `lane[15:0]`, extended the same way.
  - LW uses `mem_rdata` unshifted and ignores `off`.
  - Funct3 values 011, 110 and 111 are formatted as LW and set `protocol_err`.
- **Skid register.** One entry, holding `{rd, data}`. `alu_ready = !skid_valid`.
- **Source select each cycle**, in priority order:
  1. Load response (`mem_rvalid` with a non-empty queue).
  2. Skid entry.
  3. Accepted ALU input.
- **Losing ALU input.** An ALU input accepted in a cycle it loses arbitration goes to the skid. The skid only receives an input when it is empty, so it never overflows.
- **Skid drain.** When the skid drains and a load response is absent, the skid writes; `alu_ready` is 0 that cycle, so no new ALU input is taken.
- **Register x0.** A selected write with rd = 0 produces `rd_we = 0` but still consumes the source. Loads to x0 are queued and popped normally and never set `pending`.
- **Scoreboard.** `pending` is the OR over valid queue entries of the one-hot of their rd. It is combinational from queue state, so it is updated the cycle after a push or pop.
- **Protocol errors.** `mem_rvalid` with an empty queue is dropped and sets `protocol_err`. `protocol_err` clears only on `rst`.

## Timing
- **Registered outputs.** `rd`, `rd_data` and `rd_we` are registered: a source selected in cycle N appears at the port in cycle N+1, asserted for one cycle.
- **Latencies.**
  - ALU: 1 cycle if unopposed; 2 cycles if it loses to a load response.
  - Load response: 1 cycle from `mem_rvalid`.
- **Back-to-back.** Sustains one write per cycle indefinitely. An ALU stream plus a single concurrent load response costs the ALU one `alu_ready = 0` cycle.
- **Reset values.**
  - `rd_we = 0`, `rd = 0`, `rd_data = 0`.
  - Queue empty, skid empty.
  - `alu_ready = 1`, `ld_ready = 1`, `pending = 0`, `protocol_err = 0`.
- **Reset mid-operation.** All queued loads and the skid are discarded. Any response arriving after reset is treated as unexpected and sets `protocol_err`.
- **Simultaneous issue and response** for the same rd: `pending[rd]` stays set, because the new entry still targets rd.

## Test plan
- **Basic ALU write.** Reset, then `alu_valid` with rd = 5, data = 0x1234_5678 at cycle 0 → cycle 1: `rd_we = 1`, `rd = 5`, `rd_data = 0x12345678`; then `rd_we = 0`.
- **Load formatting and scoreboard.**
  - Stimulus: issue LB rd = 3, off = 2; respond two cycles later with `mem_rdata = 0x0080_0000`.
  - `pending[3]` = 1 from the cycle after issue until the cycle after the response.
  - Response writes rd = 3, data = 0xFFFF_FF80.
  - Repeating with LBU writes 0x0000_0080; LHU with off = 2 and 0xBEEF_0000 writes 0x0000_BEEF.
- **Collision.** ALU (rd = 7, 0xA) and a load response (rd = 9, LW 0xB) in the same cycle → rd = 9 written at N+1, rd = 7 at N+2. `alu_ready = 0` at N+1, and a held ALU input (rd = 8) is written at N+3.
- **Full queue.**
  - Issue 4 loads → `ld_ready = 0`; a fifth issue is ignored.
  - An issue together with a response while full → issue refused, count becomes 3.
  - 4 responses drain the queue in FIFO order.
- **x0 and errors.**
  - An ALU write to rd = 0 → `rd_we` stays 0.
  - `mem_rvalid` with an empty queue → `protocol_err = 1`, no write, flag holds until `rst`.
  - funct3 = 011 → LW data written and `protocol_err` set.
- **Reset mid-flight.** 2 loads pending plus a skid entry, then `rst` → next cycle `pending = 0`, `rd_we = 0`, `alu_ready = 1`, `ld_ready = 1`.
